// File: rtl/binary_to_gray_if.sv
// Bundle of the encoder's data/status signals for benches and wrappers that
// prefer to route the binary_to_gray block through a single handle.
interface binary_to_gray_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] binary;
    logic [WIDTH-1:0] gray;
    logic             en;
    logic [WIDTH-1:0] gray_q;
    logic             valid_q;
    logic             step_err;

    modport master (
        output binary, en,
        input  gray, gray_q, valid_q, step_err
    );

    modport slave (
        input  binary, en,
        output gray, gray_q, valid_q, step_err
    );
endinterface

// File: rtl/binary_to_gray.sv
// Binary-to-reflected-Gray encoder with a registered copy of the code and a
// sticky flag for any loaded code step of more than one bit.
module binary_to_gray #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] gray_q,
    output logic             valid_q,
    output logic             step_err
);

    logic [WIDTH-1:0] diff;
    logic             multi_bit;

    assign gray = binary ^ (binary >> 1);

    // Clearing the lowest set bit leaves something only if two or more bits differ.
    always_comb begin
        diff      = gray ^ gray_q;
        multi_bit = |(diff & (diff - WIDTH'(1)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q   <= '0;
            valid_q  <= 1'b0;
            step_err <= 1'b0;
        end else if (en) begin
            gray_q  <= gray;
            valid_q <= 1'b1;
            if (valid_q && multi_bit)
                step_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_binary_to_gray.sv
// Directed bench for binary_to_gray: combinational sweep, async reset,
// registered path scoreboard, step-error stickiness and WIDTH=1/8 instances.
module tb_binary_to_gray;

    logic clk;
    logic rst_n;
    logic en8, en1;
    logic [7:0] binary8, gray8, gray_q8;
    logic valid_q8, step_err8;
    logic [0:0] binary1, gray1, gray_q1;
    logic valid_q1, step_err1;

    int n_vec;
    int n_err;

    logic [3:0] gray_tab [16];
    logic [3:0] sb_q [$];
    logic [3:0] m_prev;
    logic       m_valid;
    logic       m_err;

    binary_to_gray_if #(.WIDTH(4)) bus ();

    binary_to_gray #(.WIDTH(4)) dut (
        .binary  (bus.binary),
        .gray    (bus.gray),
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.en),
        .gray_q  (bus.gray_q),
        .valid_q (bus.valid_q),
        .step_err(bus.step_err)
    );

    binary_to_gray #(.WIDTH(8)) dut8 (
        .binary  (binary8),
        .gray    (gray8),
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en8),
        .gray_q  (gray_q8),
        .valid_q (valid_q8),
        .step_err(step_err8)
    );

    binary_to_gray #(.WIDTH(1)) dut1 (
        .binary  (binary1),
        .gray    (gray1),
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en1),
        .gray_q  (gray_q1),
        .valid_q (valid_q1),
        .step_err(step_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one en-qualified load, push its expected code, compare after the edge.
    task automatic load(input logic [3:0] b);
        logic [3:0] exp;
        @(negedge clk);
        bus.binary = b;
        bus.en     = 1'b1;
        sb_q.push_back(gray_tab[b]);
        @(posedge clk);
        #1;
        bus.en = 1'b0;
        if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            exp = sb_q.pop_front();
            if (m_valid && $countones(exp ^ m_prev) > 1) m_err = 1'b1;
            m_prev  = exp;
            m_valid = 1'b1;
            check($sformatf("gray_q[b=%0d]", b), {4'h0, bus.gray_q}, {4'h0, exp});
            check($sformatf("valid_q[b=%0d]", b), {7'h0, bus.valid_q}, 8'h01);
            check($sformatf("step_err[b=%0d]", b), {7'h0, bus.step_err}, {7'h0, m_err});
        end
    endtask

    task automatic pulse_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_gray_q", {4'h0, bus.gray_q}, 8'h00);
        check("rst_valid_q", {7'h0, bus.valid_q}, 8'h00);
        check("rst_step_err", {7'h0, bus.step_err}, 8'h00);
        #1;
        rst_n   = 1'b1;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_prev  = 4'h0;
    endtask

    initial begin
        logic [3:0] held;
        gray_tab = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                     4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        n_vec   = 0;
        n_err   = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_prev  = 4'h0;
        rst_n      = 1'b0;
        bus.en     = 1'b0;
        bus.binary = 4'h0;
        en8 = 1'b0; binary8 = 8'h00;
        en1 = 1'b0; binary1 = 1'b0;
        #2;
        check("init_gray_q", {4'h0, bus.gray_q}, 8'h00);
        check("init_valid_q", {7'h0, bus.valid_q}, 8'h00);
        check("init_step_err", {7'h0, bus.step_err}, 8'h00);
        #1;
        rst_n = 1'b1;

        // Combinational sweep, en low so only gray may move.
        for (int b = 0; b < 16; b++) begin
            bus.binary = 4'(b);
            #1;
            check($sformatf("comb_gray[%0d]", b), {4'h0, bus.gray}, {4'h0, gray_tab[b]});
        end
        check("sweep_valid_q_idle", {7'h0, bus.valid_q}, 8'h00);

        // Async reset with gray_q holding 1010.
        load(4'd12);
        pulse_reset();

        // Counting sequence with wrap.
        for (int b = 0; b < 16; b++) load(4'(b));
        load(4'd0);

        // Adjacent jump, then an illegal two-bit step, then stickiness.
        load(4'b0011);
        load(4'b1100);
        check("jump_adjacent_no_err", {7'h0, bus.step_err}, 8'h00);
        load(4'b0000);
        check("jump_two_bit_err", {7'h0, bus.step_err}, 8'h01);
        load(4'b0001);
        load(4'b0001);
        check("err_sticky", {7'h0, bus.step_err}, 8'h01);
        pulse_reset();

        // Hold while en low, binary still moving.
        load(4'd5);
        held = gray_tab[5];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.binary = 4'(9 + i);
            @(posedge clk);
            #1;
            check($sformatf("hold_gray[%0d]", i), {4'h0, bus.gray}, {4'h0, gray_tab[9 + i]});
            check($sformatf("hold_gray_q[%0d]", i), {4'h0, bus.gray_q}, {4'h0, held});
            check($sformatf("hold_valid_q[%0d]", i), {7'h0, bus.valid_q}, 8'h01);
        end

        // Other widths.
        binary8 = 8'hFF;
        #1;
        check("w8_ff", gray8, 8'h80);
        binary8 = 8'hA5;
        #1;
        check("w8_a5", gray8, 8'hF7);
        binary1 = 1'b0;
        #1;
        check("w1_0", {7'h0, gray1}, 8'h00);
        binary1 = 1'b1;
        #1;
        check("w1_1", {7'h0, gray1}, 8'h01);

        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/binary_to_gray.md
Name: binary_to_gray

Overview:
- Parameterised binary-to-reflected-Gray encoder.
- Primary output is a purely combinational Gray code of the input binary word.
- A clocked side path registers the Gray code and flags any non-adjacent code transitions.
- Used at clock-domain-crossing pointer boundaries (e.g. async FIFO pointers) and anywhere a single-bit-change code is required.

Parameters:
- WIDTH, 4, bit width of the binary input and all Gray outputs; legal range ≥1. It is the first (positional) parameter.

Ports:
- clk  input  1  system clock, rising-edge; used only by the registered side path.
- rst_n  input  1  asynchronous active-low reset for the registered side path.
- binary  input  WIDTH  unsigned binary value to encode.
- gray  output  WIDTH  combinational Gray code of binary.
- en  input  1  load enable for the registered path.
- gray_q  output  WIDTH  registered Gray code.
- valid_q  output  1  gray_q holds a loaded value since reset.
- step_err  output  1  sticky flag: two consecutive loaded codes differed in more than one bit.

Behaviour:
- Port declaration order is binary, gray, clk, rst_n, en, gray_q, valid_q, step_err. Positional instantiation with only (binary, gray) must elaborate and encode correctly.
- Combinational encoding: gray = binary ^ (binary >> 1).
  - gray[WIDTH-1] = binary[WIDTH-1].
  - gray[i] = binary[i+1] ^ binary[i] for i < WIDTH-1.
  - No clock or reset dependency; zero-cycle latency. Output settles within the same timestep as any input change.
- WIDTH=1: gray = binary.
- Registered path, asynchronous reset (rst_n low, any time including mid-operation): gray_q=0, valid_q=0, step_err=0 immediately, without waiting for clk.
- On rising clk with rst_n high and en=1:
  - gray_q <= gray (current combinational value).
  - valid_q <= 1.
  - If valid_q was already 1 and popcount(gray ^ gray_q) > 1, step_err <= 1.
  - Identical consecutive codes (distance 0) are not errors.
  - Wrap from all-ones binary to 0 (Gray 100..0 -> 000..0) is distance 1, not an error.
- en=0: all registers hold.
- step_err is sticky; only rst_n clears it.
- The first load after reset never sets step_err.
- Registered path latency: one clock from en-qualified edge to gray_q update.
- If clk or rst_n is unconnected, gray must still be correct; registered outputs are then don't-care.

Test Plan:
- Exhaustive WIDTH=4 combinational sweep, binary changed with no clock; gray checked after settle:
  - 0->0000, 1->0001, 2->0011, 3->0010
  - 4->0110, 5->0111, 6->0101, 7->0100
  - 8->1100, 9->1101, 10->1111, 11->1110
  - 12->1010, 13->1011, 14->1001, 15->1000
- Reset: drive rst_n low between clock edges with gray_q=1010 -> gray_q=0000, valid_q=0, step_err=0 immediately.
- Incrementing counter 0..15 then wrap to 0, en=1 every cycle -> gray_q follows the sweep one cycle late; step_err stays 0; valid_q=1 after the first edge.
- Jump binary 0011->1100 with en=1 (Gray 0010->1010, distance 1) -> step_err=0.
  - Then binary 1100->0000 (Gray 1010->0000, distance 2) -> step_err=1.
  - step_err remains 1 after later legal steps until rst_n is asserted.
- en=0 for 3 cycles while binary changes -> gray tracks binary combinationally; gray_q and valid_q unchanged.
- WIDTH=1 and WIDTH=8 elaboration:
  - WIDTH=8: binary 0xFF->gray 0x80, binary 0xA5->gray 0xF7.
  - WIDTH=1: gray equals binary.
